// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM: state
// encoding, opcode values, datapath select encodings and the control word.
package mc_ctrl_pkg;

    localparam int MC_OP_W    = 6;
    localparam int MC_STATE_W = 4;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12,
        TRAP      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    // True for the opcodes this controller sequences.
    function automatic logic op_known(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: known = 1'b1;
            default:                                       known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state-to-control-word decode for the main control FSM.
// The only non-Moore terms are the mem_ready gating in FETCH/MEM_WRITE and
// the unknown-opcode completion pulse in DECODE.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (adds illegal_op output).
module mc_output_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic       illegal_op,
`endif
    output ctrl_t      ctrl
);

    // Decode the control word; everything not named in a state stays 0.
    always_comb begin
        ctrl = '0;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_op = 1'b0;
`endif
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // PC and IR load only on the completing cycle so PC+4 happens once
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUSRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
`ifdef ILLEGAL_OP_TRAP_EN
                ctrl.instr_done = 1'b0;
`else
                // Unknown opcode retires as a NOP in this cycle
                ctrl.instr_done = ~op_known(opcode);
`endif
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUSRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ADDI_WB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP: begin
                illegal_op = 1'b1;
            end
`endif
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle MIPS main control FSM. Holds the state and the opcode latched
// in DECODE; the control word comes from mc_output_decode.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unknown opcodes park in TRAP
// and raise illegal_op; otherwise they retire as a NOP).
module multicycle_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = MC_OP_W,
    parameter int STATE_W = MC_STATE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [STATE_W-1:0] state_o
);

    state_t          state;
    logic [OP_W-1:0] op_latched;
    ctrl_t           ctrl;

    // State sequencing; the opcode is captured in DECODE for MEM_ADDR's lw/sw split.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_latched <= '0;
        end else begin
            case (state)
                IDLE:  state <= FETCH;
                FETCH: state <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    op_latched <= opcode;
                    case (opcode)
                        OP_RTYPE:     state <= R_EXEC;
                        OP_LW, OP_SW: state <= MEM_ADDR;
                        OP_BEQ:       state <= BRANCH;
                        OP_J:         state <= JUMP;
                        OP_ADDI:      state <= ADDI_EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
                        default:      state <= TRAP;
`else
                        default:      state <= FETCH;
`endif
                    endcase
                end
                MEM_ADDR:  state <= (op_latched == OP_LW) ? MEM_READ : MEM_WRITE;
                MEM_READ:  state <= mem_ready ? MEM_WB : MEM_READ;
                MEM_WB:    state <= FETCH;
                MEM_WRITE: state <= mem_ready ? FETCH : MEM_WRITE;
                R_EXEC:    state <= R_WB;
                R_WB:      state <= FETCH;
                BRANCH:    state <= FETCH;
                JUMP:      state <= FETCH;
                ADDI_EXEC: state <= ADDI_WB;
                ADDI_WB:   state <= FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
                TRAP:      state <= TRAP;
`endif
                default:   state <= IDLE;
            endcase
        end
    end

    mc_output_decode u_decode (
        .state      (state),
        .mem_ready  (mem_ready),
        .opcode     (opcode),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op (illegal_op),
`endif
        .ctrl       (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign instr_done  = ctrl.instr_done;
    assign state_o     = state;

endmodule
